// File: rtl/mat_proc_mem_pkg.sv
// mat_proc_mem_pkg: shared types for the matrix-processor memory responder
package mat_proc_mem_pkg;
  localparam int MP_W = 32;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} resp_state_t;
  typedef struct packed {
    logic [MP_W-1:0] addr;
    logic [MP_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/mat_proc_mem_responder_if.sv
// mat_proc_mem_responder_if: processor read/write port plus single-port memory bus
interface mat_proc_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             rd_req;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             idle;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_gnt;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  modport slave (
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data, mem_gnt, mem_rvalid, mem_rdata,
    output rd_data, rd_valid, wr_ready, idle, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output rd_req, rd_addr, wr_en, wr_addr, wr_data, mem_gnt, mem_rvalid, mem_rdata,
    input  rd_data, rd_valid, wr_ready, idle, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mat_proc_mem_wbuf.sv
// mat_proc_mem_wbuf: write FIFO with parallel RAW address compare
// hit_data_o comes from the youngest matching entry so forwarding returns the latest write
module mat_proc_mem_wbuf
  import mat_proc_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  wb_entry_t       din_i,
  input  logic [MP_W-1:0] addr_i,
  output wb_entry_t       head_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            hit_o,
  output logic [MP_W-1:0] hit_data_o
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t     mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  logic [AW-1:0] idx;
  logic          full_q, full_d;
  always_comb begin
    wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_i ? rptr_q + 1'b1 : rptr_q;
    full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end
  // scan oldest to youngest so the last match wins
  always_comb begin
    cnt = wptr_q - rptr_q;
    hit_o = 1'b0;
    hit_data_o = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q[AW-1:0] + AW'(k);
      if ((AW+1)'(k) < cnt && mem_q[idx].addr == addr_i) begin
        hit_o = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      full_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      full_q <= full_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = full_q;
endmodule

// File: rtl/mat_proc_mem_responder.sv
// mat_proc_mem_responder: buffers processor writes and arbitrates reads/writes onto one memory bus
// Define MAT_PROC_MEM_FWD_EN to serve RAW-hazard reads straight from the write buffer
module mat_proc_mem_responder
  import mat_proc_mem_pkg::*;
#(
  parameter int WIDTH    = MP_W,
  parameter int WB_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  mat_proc_mem_responder_if.slave bus
);
`ifdef MAT_PROC_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  resp_state_t      state_q, state_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wb_empty, wb_full, wb_hit, push, pop, rd_go, fwd, rd_ret;
  logic [WIDTH-1:0] hit_data;
  wb_entry_t        head, wr_entry;
  assign wr_entry = '{addr: bus.wr_addr, data: bus.wr_data};
  assign push     = bus.wr_en && !wb_full;
  assign pop      = state_q == WR_REQ && bus.mem_gnt;
  // the request is still held during its rd_valid cycle; don't reissue it
  assign rd_go    = bus.rd_req && !rd_valid_q;
  assign fwd      = FWD && state_q == IDLE && !wb_full && rd_go && wb_hit;
  assign rd_ret   = state_q == RD_WAIT && bus.mem_rvalid;
  mat_proc_mem_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .pop_i     (pop),
    .din_i     (wr_entry),
    .addr_i    (bus.rd_addr),
    .head_o    (head),
    .empty_o   (wb_empty),
    .full_o    (wb_full),
    .hit_o     (wb_hit),
    .hit_data_o(hit_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end
  // a full buffer outranks reads so wr_ready can recover
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = wb_full ? WR_REQ :
                         (rd_go && !wb_hit) ? RD_REQ :
                         (rd_go && FWD) ? IDLE :
                         !wb_empty ? WR_REQ : IDLE;
      RD_REQ:  state_d = bus.mem_gnt ? RD_WAIT : RD_REQ;
      RD_WAIT: state_d = bus.mem_rvalid ? IDLE : RD_WAIT;
      WR_REQ:  state_d = bus.mem_gnt ? IDLE : WR_REQ;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_valid_d    = rd_ret || fwd;
    rd_data_d     = rd_ret ? bus.mem_rdata : fwd ? hit_data : rd_data_q;
    bus.mem_req   = state_q == RD_REQ || state_q == WR_REQ;
    bus.mem_we    = state_q == WR_REQ;
    bus.mem_addr  = state_q == WR_REQ ? head.addr : state_q == RD_REQ ? bus.rd_addr : '0;
    bus.mem_wdata = state_q == WR_REQ ? head.data : '0;
  end
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.wr_ready = !wb_full;
  assign bus.idle     = wb_empty && state_q == IDLE && !bus.rd_req;
endmodule
